modaddsub_vec: RTL and testbench

Multi-lane pipelined modular add/subtract unit: per transaction, each of LANES lanes computes (a + b) mod MOD or (a − b) mod MOD, selected per transaction by a mode bit. It generalises the single-lane, fixed-subtract, no-backpressure modsub. It adds lane vectorisation, add/sub mode and a valid/ready handshake so it can sit between stalling NTT/butterfly stages in the MVP datapath.

---
 rtl/modaddsub_vec_pkg.sv | 22 ++
 rtl/modaddsub_lane.sv | 41 ++++
 rtl/modaddsub_vec.sv | 133 +++++++++++++
 tb/tb_modaddsub_vec.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modaddsub_vec_pkg.sv
// Shared definitions for the vectorised modular add/subtract unit:
// pipeline delay, mode encodings and the mode enum.
`ifndef COMMON_MODADDSUB_DELAY
`define COMMON_MODADDSUB_DELAY 2
`endif
`ifndef MODADDSUB_MODE_SUB
`define MODADDSUB_MODE_SUB 1'b0
`endif
`ifndef MODADDSUB_MODE_ADD
`define MODADDSUB_MODE_ADD 1'b1
`endif

package modaddsub_vec_pkg;

    localparam int unsigned MODADDSUB_DELAY = `COMMON_MODADDSUB_DELAY;

    typedef enum logic {
        MODE_SUB = `MODADDSUB_MODE_SUB,
        MODE_ADD = `MODADDSUB_MODE_ADD
    } mode_e;

endpackage

// File: rtl/modaddsub_lane.sv
// One lane of the modular add/subtract datapath: combinational S1 raw
// add/subtract and S2 modular correction. Holds no state.
module modaddsub_lane
    import modaddsub_vec_pkg::*;
#(
    parameter int unsigned       MWIDTH = 39,
    parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001
) (
    input  logic [MWIDTH-1:0] i_a,
    input  logic [MWIDTH-1:0] i_b,
    input  mode_e             i_mode,
    output logic [MWIDTH:0]   o_raw,
    input  logic [MWIDTH:0]   i_raw,
    input  mode_e             i_raw_mode,
    output logic [MWIDTH-1:0] o_res
);

    logic [MWIDTH-1:0] add_fix;
    logic [MWIDTH-1:0] sub_fix;

    always_comb begin
        if (i_mode == MODE_ADD) begin
            o_raw = {1'b0, i_a} + {1'b0, i_b};
        end else begin
            o_raw = {1'b0, i_a} - {1'b0, i_b};
        end
    end

    // Both corrections are done modulo 2^MWIDTH; for in-range operands the
    // true result always fits, so the dropped carry/borrow is irrelevant.
    always_comb begin
        add_fix = i_raw[MWIDTH-1:0] - MOD;
        sub_fix = i_raw[MWIDTH-1:0] + MOD;
        if (i_raw_mode == MODE_ADD) begin
            o_res = (i_raw >= {1'b0, MOD}) ? add_fix : i_raw[MWIDTH-1:0];
        end else begin
            o_res = i_raw[MWIDTH] ? sub_fix : i_raw[MWIDTH-1:0];
        end
    end

endmodule

// File: rtl/modaddsub_vec.sv
// Multi-lane two-stage pipelined modular add/subtract with valid/ready.
// Define MODADDSUB_RANGE_CHK_EN to build the operand range-error flag (o_err).
module modaddsub_vec
    import modaddsub_vec_pkg::*;
#(
    parameter int unsigned       MWIDTH = 39,
    parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001,
    parameter int unsigned       LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vld,
    output logic                    o_rdy,
    input  logic                    i_mode,
    input  logic [LANES*MWIDTH-1:0] i_din_0,
    input  logic [LANES*MWIDTH-1:0] i_din_1,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [LANES*MWIDTH-1:0] o_dout,
    output logic                    o_err
);

    logic                          s1_adv;
    logic                          s2_adv;
    mode_e                         in_mode;

    logic                          s1_vld_q, s1_vld_d;
    logic [LANES-1:0][MWIDTH:0]    s1_raw_q, s1_raw_d;
    mode_e                         s1_mode_q, s1_mode_d;
    logic                          s2_vld_q, s2_vld_d;
    logic [LANES*MWIDTH-1:0]       s2_dout_q, s2_dout_d;

    logic [LANES-1:0][MWIDTH:0]    lane_raw;
    logic [LANES*MWIDTH-1:0]       lane_res;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        modaddsub_lane #(
            .MWIDTH (MWIDTH),
            .MOD    (MOD)
        ) u_lane (
            .i_a        (i_din_0[k*MWIDTH +: MWIDTH]),
            .i_b        (i_din_1[k*MWIDTH +: MWIDTH]),
            .i_mode     (in_mode),
            .o_raw      (lane_raw[k]),
            .i_raw      (s1_raw_q[k]),
            .i_raw_mode (s1_mode_q),
            .o_res      (lane_res[k*MWIDTH +: MWIDTH])
        );
    end

    // Data registers only load on a valid advance; bubbles drop valid only.
    always_comb begin
        in_mode   = mode_e'(i_mode);
        s2_adv    = ~s2_vld_q | i_rdy;
        s1_adv    = ~s1_vld_q | s2_adv;
        s1_vld_d  = s1_vld_q;
        s1_raw_d  = s1_raw_q;
        s1_mode_d = s1_mode_q;
        s2_vld_d  = s2_vld_q;
        s2_dout_d = s2_dout_q;
        if (s1_adv) begin
            s1_vld_d = i_vld;
            if (i_vld) begin
                s1_raw_d  = lane_raw;
                s1_mode_d = in_mode;
            end
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_dout_d = lane_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_raw_q  <= '0;
            s1_mode_q <= MODE_SUB;
            s2_vld_q  <= 1'b0;
            s2_dout_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_raw_q  <= s1_raw_d;
            s1_mode_q <= s1_mode_d;
            s2_vld_q  <= s2_vld_d;
            s2_dout_q <= s2_dout_d;
        end
    end

    assign o_rdy  = s1_adv;
    assign o_vld  = s2_vld_q;
    assign o_dout = s2_dout_q;

`ifdef MODADDSUB_RANGE_CHK_EN
    logic in_err;
    logic s1_err_q, s1_err_d;
    logic s2_err_q, s2_err_d;

    always_comb begin
        in_err = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            in_err = in_err
                   | (i_din_0[k*MWIDTH +: MWIDTH] >= MOD)
                   | (i_din_1[k*MWIDTH +: MWIDTH] >= MOD);
        end
        s1_err_d = s1_err_q;
        s2_err_d = s2_err_q;
        if (s1_adv && i_vld) begin
            s1_err_d = in_err;
        end
        if (s2_adv && s1_vld_q) begin
            s2_err_d = s1_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err_q <= 1'b0;
            s2_err_q <= 1'b0;
        end else begin
            s1_err_q <= s1_err_d;
            s2_err_q <= s2_err_d;
        end
    end

    assign o_err = s2_err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_modaddsub_vec.sv
// Self-checking bench for modaddsub_vec (MOD=17, MWIDTH=5, LANES=2) against a
// plain-arithmetic reference model and a transaction scoreboard.
module tb_modaddsub_vec;

    localparam int unsigned MW   = 5;
    localparam int unsigned LN   = 2;
    localparam int unsigned DW   = MW * LN;
    localparam int          MODI = 17;
    localparam logic [MW-1:0] MODV = 5'd17;

    logic          clk;
    logic          rst_n;
    logic          i_vld;
    logic          o_rdy;
    logic          i_mode;
    logic [DW-1:0] i_din_0;
    logic [DW-1:0] i_din_1;
    logic          o_vld;
    logic          i_rdy;
    logic [DW-1:0] o_dout;
    logic          o_err;

    int checks;
    int failures;

    modaddsub_vec #(
        .MWIDTH (MW),
        .MOD    (MODV),
        .LANES  (LN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_mode  (i_mode),
        .i_din_0 (i_din_0),
        .i_din_1 (i_din_1),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_dout  (o_dout),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_vec(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input logic mode);
        logic [DW-1:0] r;
        int a, b, v;
        r = '0;
        for (int k = 0; k < int'(LN); k++) begin
            a = 32'(x[k*MW +: MW]);
            b = 32'(y[k*MW +: MW]);
            v = mode ? (a + b) % MODI : (a - b + MODI) % MODI;
            r[k*MW +: MW] = v[MW-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(LN); k++) begin
            r[k*MW +: MW] = 5'($urandom_range(MODI - 1, 0));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL reset_o_vld got=%0b exp=0", o_vld); end
        checks++; if (o_dout !== '0) begin failures++; $display("FAIL reset_o_dout got=%0h exp=0", o_dout); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_o_err got=%0b exp=0", o_err); end
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL reset_o_rdy got=%0b exp=1", o_rdy); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [DW-1:0] a, b, e;
        i_rdy = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin
                a = {5'd16, 5'd9};
                b = {5'd1, 5'd12};
                e = {5'd0, 5'd4};
            end else begin
                a = rnd_vec();
                b = rnd_vec();
                e = ref_vec(a, b, 1'b1);
            end
            i_vld = 1'b1; i_mode = 1'b1; i_din_0 = a; i_din_1 = b;
            step();
            i_vld = 1'b0;
            checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL add_early_vld n=%0d got=%0b exp=0", n, o_vld); end
            step();
            checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL add_vld n=%0d got=%0b exp=1", n, o_vld); end
            checks++; if (o_dout !== e) begin failures++; $display("FAIL add_dout n=%0d got=%0h exp=%0h", n, o_dout, e); end
            step();
            checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL add_vld_drop n=%0d got=%0b exp=0", n, o_vld); end
        end
    endtask

    task automatic test_sub();
        logic [DW-1:0] a, b, e;
        i_rdy = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin
                a = {5'd10, 5'd3};
                b = {5'd3, 5'd10};
                e = {5'd7, 5'd10};
            end else if (n == 1) begin
                a = {5'd5, 5'd0};
                b = {5'd5, 5'd16};
                e = {5'd0, 5'd1};
            end else begin
                a = rnd_vec();
                b = rnd_vec();
                e = ref_vec(a, b, 1'b0);
            end
            i_vld = 1'b1; i_mode = 1'b0; i_din_0 = a; i_din_1 = b;
            step();
            i_vld = 1'b0;
            checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL sub_early_vld n=%0d got=%0b exp=0", n, o_vld); end
            step();
            checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL sub_vld n=%0d got=%0b exp=1", n, o_vld); end
            checks++; if (o_dout !== e) begin failures++; $display("FAIL sub_dout n=%0d got=%0h exp=%0h", n, o_dout, e); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a[8];
        logic [DW-1:0] b[8];
        logic [DW-1:0] e[8];
        for (int i = 0; i < 8; i++) begin
            a[i] = rnd_vec();
            b[i] = rnd_vec();
            e[i] = ref_vec(a[i], b[i], 1'(i % 2));
        end
        i_rdy = 1'b1;
        i_vld = 1'b1; i_mode = 1'b0; i_din_0 = a[0]; i_din_1 = b[0];
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k >= 2 && k <= 9) begin
                checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL b2b_vld k=%0d got=%0b exp=1", k, o_vld); end
                checks++; if (o_dout !== e[k-2]) begin failures++; $display("FAIL b2b_dout k=%0d got=%0h exp=%0h", k, o_dout, e[k-2]); end
            end
            if (k == 10) begin
                checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL b2b_extra_vld got=%0b exp=0", o_vld); end
            end
            if (k < 8) begin
                checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy k=%0d got=%0b exp=1", k, o_rdy); end
                i_mode = 1'(k % 2); i_din_0 = a[k]; i_din_1 = b[k];
            end else begin
                i_vld = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a[3];
        logic [DW-1:0] b[3];
        logic [DW-1:0] e[3];
        logic          m[3];
        for (int i = 0; i < 3; i++) begin
            a[i] = rnd_vec();
            b[i] = rnd_vec();
            m[i] = 1'($urandom_range(1, 0));
            e[i] = ref_vec(a[i], b[i], m[i]);
        end
        i_rdy = 1'b0;
        i_vld = 1'b1; i_mode = m[0]; i_din_0 = a[0]; i_din_1 = b[0];
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_empty got=%0b exp=1", o_rdy); end
        step();
        i_mode = m[1]; i_din_0 = a[1]; i_din_1 = b[1];
        checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL bp_vld_one got=%0b exp=0", o_vld); end
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_one got=%0b exp=1", o_rdy); end
        step();
        i_mode = m[2]; i_din_0 = a[2]; i_din_1 = b[2];
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL bp_stall_vld k=%0d got=%0b exp=1", k, o_vld); end
            checks++; if (o_dout !== e[0]) begin failures++; $display("FAIL bp_stall_dout k=%0d got=%0h exp=%0h", k, o_dout, e[0]); end
            checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL bp_full_rdy k=%0d got=%0b exp=0", k, o_rdy); end
            if (k < 2) step();
        end
        i_rdy = 1'b1;
        #1;
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_rdy got=%0b exp=1", o_rdy); end
        step();
        i_vld = 1'b0;
        checks++; if (o_vld !== 1'b1 || o_dout !== e[1]) begin failures++; $display("FAIL bp_drain1 vld=%0b got=%0h exp=%0h", o_vld, o_dout, e[1]); end
        step();
        checks++; if (o_vld !== 1'b1 || o_dout !== e[2]) begin failures++; $display("FAIL bp_drain2 vld=%0b got=%0h exp=%0h", o_vld, o_dout, e[2]); end
        step();
        checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL bp_dup got=%0b exp=0", o_vld); end
    endtask

    task automatic test_random_stall();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] prev_dout;
        logic          exp_rdy;
        logic          prev_stall;
        prev_stall = 1'b0;
        prev_dout  = '0;
        for (int n = 0; n < 330; n++) begin
            if (n < 300) begin
                i_vld   = 1'($urandom_range(1, 0));
                i_rdy   = ($urandom_range(3, 0) != 0);
                i_mode  = 1'($urandom_range(1, 0));
                i_din_0 = rnd_vec();
                i_din_1 = rnd_vec();
            end else begin
                i_vld = 1'b0;
                i_rdy = 1'b1;
            end
            #1;
            exp_rdy = (q.size() < 2) || i_rdy;
            checks++; if (o_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_rdy n=%0d got=%0b exp=%0b", n, o_rdy, exp_rdy); end
            if (prev_stall) begin
                checks++; if (o_vld !== 1'b1 || o_dout !== prev_dout) begin failures++; $display("FAIL rnd_hold n=%0d vld=%0b got=%0h exp=%0h", n, o_vld, o_dout, prev_dout); end
            end
            if (q.size() == 0) begin
                checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL rnd_spurious n=%0d got=%0b exp=0", n, o_vld); end
            end else if (o_vld === 1'b1 && i_rdy) begin
                exp_d = q.pop_front();
                checks++; if (o_dout !== exp_d) begin failures++; $display("FAIL rnd_dout n=%0d got=%0h exp=%0h", n, o_dout, exp_d); end
                checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rnd_err n=%0d got=%0b exp=0", n, o_err); end
            end
            if (i_vld && exp_rdy) q.push_back(ref_vec(i_din_0, i_din_1, i_mode));
            prev_stall = o_vld && !i_rdy;
            prev_dout  = o_dout;
            step();
        end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d pending exp=0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        i_rdy = 1'b0;
        i_vld = 1'b1; i_mode = 1'b1; i_din_0 = rnd_vec(); i_din_1 = rnd_vec();
        step();
        i_din_0 = rnd_vec(); i_din_1 = rnd_vec();
        step();
        i_vld = 1'b0;
        checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL rstmid_inflight got=%0b exp=1", o_vld); end
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL rstmid_vld got=%0b exp=0", o_vld); end
        checks++; if (o_dout !== '0) begin failures++; $display("FAIL rstmid_dout got=%0h exp=0", o_dout); end
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_rdy got=%0b exp=1", o_rdy); end
        step();
        step();
        rst_n = 1'b1;
        i_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL rstmid_stale k=%0d got=%0b exp=0", k, o_vld); end
        end
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_rdy_after got=%0b exp=1", o_rdy); end
    endtask

    task automatic test_range();
        logic [DW-1:0] a[3];
        logic [DW-1:0] b[3];
        logic [DW-1:0] e[3];
        logic          ee[3];
        for (int i = 0; i < 3; i++) begin
            a[i] = rnd_vec();
            b[i] = rnd_vec();
            e[i] = ref_vec(a[i], b[i], 1'b1);
        end
        a[1][2*MW-1:MW] = MODV;
`ifdef MODADDSUB_RANGE_CHK_EN
        ee[0] = 1'b0; ee[1] = 1'b1; ee[2] = 1'b0;
`else
        ee[0] = 1'b0; ee[1] = 1'b0; ee[2] = 1'b0;
`endif
        i_rdy = 1'b1;
        i_vld = 1'b1; i_mode = 1'b1; i_din_0 = a[0]; i_din_1 = b[0];
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k >= 2 && k <= 4) begin
                checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL range_vld k=%0d got=%0b exp=1", k, o_vld); end
                checks++; if (o_err !== ee[k-2]) begin failures++; $display("FAIL range_err k=%0d got=%0b exp=%0b", k, o_err, ee[k-2]); end
                if (k != 3) begin
                    checks++; if (o_dout !== e[k-2]) begin failures++; $display("FAIL range_dout k=%0d got=%0h exp=%0h", k, o_dout, e[k-2]); end
                end
            end
            if (k < 3) begin
                i_din_0 = a[k]; i_din_1 = b[k];
            end else begin
                i_vld = 1'b0;
            end
        end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL range_err_idle got=%0b exp=0", o_err); end
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout reached got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        i_vld    = 1'b0;
        i_rdy    = 1'b1;
        i_mode   = 1'b0;
        i_din_0  = '0;
        i_din_1  = '0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_midflight();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
